// File: rtl/dfr0520_wiper_sched.sv
// Frame scheduler for the dual digital pot driver: arbitrates wiper/shutdown requests and keeps wiper shadows.
// Optional wiper slew limiting is compiled in when DFR0520_SLEW_EN is defined.
module dfr0520_wiper_sched #(
   parameter int unsigned FRAME_CYCLES = 40
`ifdef DFR0520_SLEW_EN
   ,
   parameter int unsigned SLEW_STEP    = 8
`endif
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       req0,
   input  logic [7:0] val0,
   input  logic       req1,
   input  logic [7:0] val1,
   input  logic       shdn_req,
   output logic [1:0] cmd,
   output logic [1:0] sel,
   output logic [7:0] data,
   output logic       EN,
   output logic       busy,
   output logic       ack0,
   output logic       ack1,
   output logic       ack_shdn,
   output logic [7:0] wiper0,
   output logic [7:0] wiper1
);

   // Requests are single-cycle pulses with no backpressure; acks are single-cycle completion pulses.
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   localparam logic [7:0] WAIT_LOAD = 8'(FRAME_CYCLES - 2);
   localparam logic [1:0] CMD_WRITE = 2'b01;
   localparam logic [1:0] CMD_SHDN  = 2'b10;
   localparam logic [1:0] SEL_P0    = 2'b01;
   localparam logic [1:0] SEL_P1    = 2'b10;
   localparam logic [1:0] SEL_BOTH  = 2'b11;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       pend0_q, pend0_d, pend1_q, pend1_d, pend_s_q, pend_s_d;
   logic [7:0] tgt0_q, tgt0_d, tgt1_q, tgt1_d;
   logic       fresh0_q, fresh0_d, fresh1_q, fresh1_d, fresh_s_q, fresh_s_d;
   logic       srv0_q, srv0_d, srv1_q, srv1_d, srv_s_q, srv_s_d;
   logic       reach0_q, reach0_d, reach1_q, reach1_d;
   logic       rr_q, rr_d;
   logic [1:0] cmd_q, cmd_d, sel_q, sel_d;
   logic [7:0] data_q, data_d;
   logic [7:0] wiper0_q, wiper0_d, wiper1_q, wiper1_d;

   logic [7:0] step0, step1;
   logic       merge_ok, pick0, any_pend, in_done;

`ifdef DFR0520_SLEW_EN
   localparam logic [8:0] SLEW_LIM = 9'(SLEW_STEP);

   // Move cur toward tgt by at most SLEW_LIM; the 9-bit difference keeps the sign so it never wraps.
   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
      logic [8:0] diff;
      diff = {1'b0, tgt} - {1'b0, cur};
      if (!diff[8])
         return (diff > SLEW_LIM) ? cur + SLEW_LIM[7:0] : tgt;
      else
         return ((-diff) > SLEW_LIM) ? cur - SLEW_LIM[7:0] : tgt;
   endfunction

   assign step0    = step_toward(wiper0_q, tgt0_q);
   assign step1    = step_toward(wiper1_q, tgt1_q);
   assign merge_ok = pend0_q && pend1_q && (tgt0_q == tgt1_q) && (wiper0_q == wiper1_q);
`else
   assign step0    = tgt0_q;
   assign step1    = tgt1_q;
   assign merge_ok = pend0_q && pend1_q && (tgt0_q == tgt1_q);
`endif

   assign any_pend = pend_s_q | pend0_q | pend1_q;
   assign pick0    = pend0_q && (!pend1_q || !rr_q);
   assign in_done  = (state_q == S_DONE);

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pend0_q   <= 1'b0;
         pend1_q   <= 1'b0;
         pend_s_q  <= 1'b0;
         tgt0_q    <= 8'h80;
         tgt1_q    <= 8'h80;
         fresh0_q  <= 1'b0;
         fresh1_q  <= 1'b0;
         fresh_s_q <= 1'b0;
         srv0_q    <= 1'b0;
         srv1_q    <= 1'b0;
         srv_s_q   <= 1'b0;
         reach0_q  <= 1'b0;
         reach1_q  <= 1'b0;
         rr_q      <= 1'b0;
         cmd_q     <= '0;
         sel_q     <= '0;
         data_q    <= '0;
         wiper0_q  <= 8'h80;
         wiper1_q  <= 8'h80;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend0_q   <= pend0_d;
         pend1_q   <= pend1_d;
         pend_s_q  <= pend_s_d;
         tgt0_q    <= tgt0_d;
         tgt1_q    <= tgt1_d;
         fresh0_q  <= fresh0_d;
         fresh1_q  <= fresh1_d;
         fresh_s_q <= fresh_s_d;
         srv0_q    <= srv0_d;
         srv1_q    <= srv1_d;
         srv_s_q   <= srv_s_d;
         reach0_q  <= reach0_d;
         reach1_q  <= reach1_d;
         rr_q      <= rr_d;
         cmd_q     <= cmd_d;
         sel_q     <= sel_d;
         data_q    <= data_d;
         wiper0_q  <= wiper0_d;
         wiper1_q  <= wiper1_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      srv0_d   = srv0_q;
      srv1_d   = srv1_q;
      srv_s_d  = srv_s_q;
      reach0_d = reach0_q;
      reach1_d = reach1_q;
      rr_d     = rr_q;
      cmd_d    = cmd_q;
      sel_d    = sel_q;
      data_d   = data_q;
      wiper0_d = wiper0_q;
      wiper1_d = wiper1_q;

      // fresh* marks a request that arrived after its channel was latched, so DONE must not clear it.
      fresh0_d  = in_done ? 1'b0 : ((state_q == S_IDLE) ? req0     : (fresh0_q  | req0));
      fresh1_d  = in_done ? 1'b0 : ((state_q == S_IDLE) ? req1     : (fresh1_q  | req1));
      fresh_s_d = in_done ? 1'b0 : ((state_q == S_IDLE) ? shdn_req : (fresh_s_q | shdn_req));

      pend0_d  = (pend0_q  && !(in_done && srv0_q && reach0_q && !fresh0_q)) || req0;
      pend1_d  = (pend1_q  && !(in_done && srv1_q && reach1_q && !fresh1_q)) || req1;
      pend_s_d = (pend_s_q && !(in_done && srv_s_q && !fresh_s_q)) || shdn_req;
      tgt0_d   = req0 ? val0 : tgt0_q;
      tgt1_d   = req1 ? val1 : tgt1_q;

      case (state_q)
         S_IDLE: begin
            if (any_pend) begin
               state_d  = S_ISSUE;
               cnt_d    = WAIT_LOAD;
               srv0_d   = 1'b0;
               srv1_d   = 1'b0;
               srv_s_d  = 1'b0;
               reach0_d = 1'b0;
               reach1_d = 1'b0;
               cmd_d    = CMD_WRITE;
               if (pend_s_q) begin
                  cmd_d   = CMD_SHDN;
                  sel_d   = SEL_BOTH;
                  data_d  = 8'h00;
                  srv_s_d = 1'b1;
               end else if (merge_ok) begin
                  sel_d    = SEL_BOTH;
                  data_d   = step0;
                  srv0_d   = 1'b1;
                  srv1_d   = 1'b1;
                  reach0_d = (step0 == tgt0_q);
                  reach1_d = (step1 == tgt1_q);
               end else if (pick0) begin
                  sel_d    = SEL_P0;
                  data_d   = step0;
                  srv0_d   = 1'b1;
                  reach0_d = (step0 == tgt0_q);
                  rr_d     = ~rr_q;
               end else begin
                  sel_d    = SEL_P1;
                  data_d   = step1;
                  srv1_d   = 1'b1;
                  reach1_d = (step1 == tgt1_q);
                  rr_d     = ~rr_q;
               end
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (cnt_q == 8'd0) state_d = S_DONE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (srv0_q) wiper0_d = data_q;
            if (srv1_q) wiper1_d = data_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign cmd      = cmd_q;
   assign sel      = sel_q;
   assign data     = data_q;
   assign EN       = (state_q == S_ISSUE);
   assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign ack0     = in_done && srv0_q && reach0_q;
   assign ack1     = in_done && srv1_q && reach1_q;
   assign ack_shdn = in_done && srv_s_q;
   assign wiper0   = wiper0_q;
   assign wiper1   = wiper1_q;

endmodule

// File: doc/dfr0520_wiper_sched.md
Name: dfr0520_wiper_sched

Overview:
Scheduler in front of the dfr0520_spi frame driver for the dual digital potentiometer.
- Accepts independent wiper-set requests for pot 0 and pot 1, plus a shutdown request.
- Arbitrates between them and issues one cmd/sel/data/EN frame at a time to the driver.
- Keeps a shadow copy of each wiper value.
- The driver has no busy output, so frame completion is timed by a fixed cycle count.

Parameters:
FRAME_CYCLES, 40, clk_in cycles from EN pulse until the driver can accept the next frame; legal range 2..255
SLEW_STEP, 8, maximum wiper change per frame; used only when DFR0520_SLEW_EN is defined; range 1..255

Ports:
clk_in  input  1  system clock; all logic on its rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  one-cycle pulse; request to set pot 0 to val0
val0  input  8  pot 0 target, sampled when req0=1
req1  input  1  one-cycle pulse; request to set pot 1 to val1
val1  input  8  pot 1 target, sampled when req1=1
shdn_req  input  1  one-cycle pulse; request a shutdown frame
cmd  output  2  to driver: 01 write, 10 shutdown
sel  output  2  to driver: 01 pot0, 10 pot1, 11 both
data  output  8  to driver: wiper byte
EN  output  1  to driver: one-cycle frame start strobe
busy  output  1  high while a frame is in flight (ISSUE or WAIT)
ack0  output  1  one-cycle pulse; pot 0 request completed
ack1  output  1  one-cycle pulse; pot 1 request completed
ack_shdn  output  1  one-cycle pulse; shutdown frame completed
wiper0  output  8  shadow value of pot 0
wiper1  output  8  shadow value of pot 1

Behaviour:
Reset (rst_n low, asynchronous):
- cmd=00, sel=00, data=00, EN=0, busy=0, all acks 0, wiper0=wiper1=8'h80.
- Pending flags cleared; round-robin pointer set to serve ch0 first; FSM to IDLE.
- Reset asserted mid-frame drops EN and busy immediately; the in-flight request is lost, no ack.

Request capture:
- reqN=1 sets pendN and loads tgtN<=valN.
- A repeat reqN while pendN is set overwrites tgtN (coalescing); only one ack results.
- shdn_req sets pend_s.

FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any pending flag is set, select a request and go to ISSUE on the next cycle.
  - Priority: pend_s first, then round-robin between pend0 and pend1.
  - The pointer toggles after each served channel frame.
- Merge: if pend0 and pend1 are both set and tgt0==tgt1, send one frame with sel=11. Both channels are served and the round-robin pointer is unchanged.
- ISSUE (1 cycle): EN=1, busy=1.
  - cmd/sel/data are registered on entry and held stable through the end of WAIT.
  - Shutdown frame: cmd=10, sel=11, data=00.
  - Write frame: cmd=01, sel per channel, data=tgt.
- WAIT: EN=0, busy=1; counter runs FRAME_CYCLES-1 cycles.
- DONE (1 cycle): busy=0.
  - Pulse the ack(s) for the served request(s).
  - Update wiper shadow(s) to the data sent; shutdown leaves the shadows unchanged.
  - Clear the served pending flag(s); return to IDLE.
- Frame period: EN pulses are spaced FRAME_CYCLES+2 cycles apart (ISSUE + FRAME_CYCLES-1 WAIT + DONE + IDLE) when back-to-back requests are queued.

Simultaneous events:
- reqN in the same cycle it is latched for ISSUE: the frame uses the old tgtN. The new value is stored and pendN stays set, so a second frame follows.
- reqN arriving during DONE for the same channel: pendN remains set with the new value.
- Clear takes priority only for the served value; the new request is preserved.
- req0, req1 and shdn_req may all arrive in one cycle: served in the order shutdown, then the round-robin channel, then the other.

Optional Feature:
DFR0520_SLEW_EN

Defined:
- Each write frame sends data = shadow moved toward tgt by min(|tgt-shadow|, SLEW_STEP). Computed with 9-bit difference; never overshoots or wraps.
- The shadow updates every frame.
- pendN clears and ackN pulses only on the frame where the shadow reaches tgtN.
- Intermediate frames keep round-robin alternation.
- Merge applies only when the targets and shadows of both channels are equal.

Undefined:
- data=tgt directly; one frame per request; no slew logic synthesized.

Test Plan:
- Reset, then req0 with val0=8'h3C -> one EN pulse with cmd=01, sel=01, data=3C. busy high FRAME_CYCLES cycles; ack0 pulses; wiper0=3C; wiper1 stays 80.
- req0 (val 10) and req1 (val 20) in the same cycle -> frame sel=01 data=10, then sel=10 data=20. EN pulses 42 cycles apart (FRAME_CYCLES=40); ack0 then ack1.
- req0 and req1 both with value 8'h55 -> a single frame sel=11 data=55; ack0 and ack1 in the same cycle; both shadows =55.
- shdn_req together with req1 (val 7F) -> first frame cmd=10 sel=11 data=00 with ack_shdn; then the write frame. Shadows unaffected by shutdown.
- req0 val 01, then req0 val 02 before ISSUE -> exactly one frame with data=02; one ack0.
- rst_n low during WAIT -> EN/busy drop at once; no ack; shadows back to 80.
- With DFR0520_SLEW_EN and SLEW_STEP=8: req0 val 8'h70 from 80 -> frames with data 78, then 70; ack0 only after the second frame.
